// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   // Sequencer states; the encoding is visible on State_o.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } state_e;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts cycles with inc_i high and sticks at all-ones.
module hazard_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // Count up on each qualifying cycle, never wrapping past all-ones.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, cache-miss
// freezes, branch flushes, memory-hang timeout and performance counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       ID_RS1_i,
   input  logic [4:0]       ID_RS2_i,
   input  logic             ID_UseRS1_i,
   input  logic             ID_UseRS2_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_Rd_i,
   input  logic             ID_Branch_Taken_i,
   input  logic             MEM_Stall_i,
   output logic             PC_Write_o,
   output logic             IF_ID_Write_o,
   output logic             IF_ID_Flush_o,
   output logic             ID_EX_Bubble_o,
   output logic             Pipe_Freeze_o,
   output logic [1:0]       State_o,
   output logic             Timeout_o,
   output logic [CNT_W-1:0] Stall_Cnt_o,
   output logic [CNT_W-1:0] LoadUse_Cnt_o,
   output logic [CNT_W-1:0] Flush_Cnt_o
);

   // A timeout of 0 still needs a 1-bit wait counter.
   localparam int WAIT_W  = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   // With a timeout of one cycle the very first stall cycle already expires it.
   localparam bit TMO_ONE = (MEM_TIMEOUT == 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;

   logic              load_use;
   logic [31:0]       wait_nxt_ext;
   logic              wait_hit;

   logic              pc_write, ifid_write, ifid_flush, idex_bubble, freeze;

   // Forwarding cannot help when the loaded value is consumed right behind the load.
   assign load_use = EX_MemRead_i && (EX_Rd_i != REG_ZERO) &&
                     ((ID_UseRS1_i && (ID_RS1_i == EX_Rd_i)) ||
                      (ID_UseRS2_i && (ID_RS2_i == EX_Rd_i)));

   // This stall cycle would be the MEM_TIMEOUT-th consecutive one.
   assign wait_nxt_ext = 32'(wait_cnt_q) + 32'd1;
   assign wait_hit     = (MEM_TIMEOUT != 0) && (wait_nxt_ext == 32'(MEM_TIMEOUT));

   // Mealy control outputs; priority is cache stall > load-use > branch > normal.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      freeze      = 1'b0;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (MEM_Stall_i) begin
               freeze = 1'b1;
            end else if (load_use) begin
               // Any simultaneous taken branch is re-resolved once the bubble clears.
               idex_bubble = 1'b1;
            end else if (ID_Branch_Taken_i) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end
         HALT: begin
            freeze = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Next-state, wait-counter and timeout-flag logic.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            if (MEM_Stall_i) begin
               if (TMO_ONE) begin
                  state_d   = HALT;
                  timeout_d = 1'b1;
               end else begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = WAIT_W'(1);
               end
            end
         end
         MEM_WAIT: begin
            if (MEM_Stall_i) begin
               if (wait_hit) begin
                  state_d   = HALT;
                  timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencer state registers; HALT is only left through reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign PC_Write_o     = pc_write;
   assign IF_ID_Write_o  = ifid_write;
   assign IF_ID_Flush_o  = ifid_flush;
   assign ID_EX_Bubble_o = idex_bubble;
   assign Pipe_Freeze_o  = freeze;
   assign State_o        = state_q;
   assign Timeout_o      = timeout_q;

   hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (freeze),
      .cnt_o (Stall_Cnt_o)
   );

   hazard_sat_counter #(.W(CNT_W)) u_loaduse_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (idex_bubble),
      .cnt_o (LoadUse_Cnt_o)
   );

   hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ifid_flush),
      .cnt_o (Flush_Cnt_o)
   );

endmodule
